// File: rtl/ref_meter_pkg.sv
//------------------------------------------------------------------------------
// ref_meter_pkg
// Shared state encoding and default sizing for the reference period meter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ref_meter_pkg;

  localparam int DEFAULT_WIDTH = 28;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//------------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchroniser for an asynchronous input plus a rising-edge pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic sig_in,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= sig_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

`default_nettype wire

// File: rtl/ref_period_meter.sv
//------------------------------------------------------------------------------
// ref_period_meter
// Averaged period / high-time meter for an asynchronous square-wave reference.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ref_period_meter
  import ref_meter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               AVG_LOG2 = 2,
  parameter logic [WIDTH-1:0] TIMEOUT  = WIDTH'(100_000_000)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               ACC_W  = WIDTH + AVG_LOG2;
  localparam int               N_W    = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]   N_LAST = N_W'((1 << AVG_LOG2) - 1);
  // A period of TIMEOUT cycles can never complete: give up one cycle before it would.
  localparam logic [WIDTH-1:0] PER_LIMIT = TIMEOUT - WIDTH'(2);

  logic             sync;
  logic             rise;
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] per;
  logic [WIDTH-1:0] hi;
  logic [ACC_W-1:0] acc_p;
  logic [ACC_W-1:0] acc_h;
  logic [N_W-1:0]   n;
  logic             start;
  logic             accept;
  logic             expire;
  logic             window_done;
  logic [ACC_W-1:0] sum_p;
  logic [ACC_W-1:0] sum_h;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .sig_in   (sig_in),
    .sync     (sync),
    .rise     (rise)
  );

  always_ff @(posedge clock_in) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          start      = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // A rise coinciding with the limit is still a valid period.
        if (rise) begin
          accept = 1'b1;
        end else if (per == PER_LIMIT) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign sum_p       = acc_p + ACC_W'(per + WIDTH'(1));
  assign sum_h       = acc_h + ACC_W'(hi + WIDTH'(sync));
  assign window_done = accept && (n == N_LAST);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      per          <= '0;
      hi           <= '0;
      acc_p        <= '0;
      acc_h        <= '0;
      n            <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (start || expire) begin
        per   <= '0;
        hi    <= '0;
        acc_p <= '0;
        acc_h <= '0;
        n     <= '0;
        if (expire) begin
          locked  <= 1'b0;
          timeout <= 1'b1;
        end
      end else if (accept) begin
        per <= '0;
        hi  <= '0;
        if (window_done) begin
          period_out   <= WIDTH'(sum_p >> AVG_LOG2);
          high_out     <= WIDTH'(sum_h >> AVG_LOG2);
          period_valid <= 1'b1;
          locked       <= 1'b1;
          timeout      <= 1'b0;
          acc_p        <= '0;
          acc_h        <= '0;
          n            <= '0;
        end else begin
          acc_p <= sum_p;
          acc_h <= sum_h;
          n     <= n + N_W'(1);
        end
      end else if (state == S_RUN) begin
        per <= per + WIDTH'(1);
        hi  <= hi + WIDTH'(sync);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ref_period_meter.sv
//------------------------------------------------------------------------------
// tb_ref_period_meter
// Bench for ref_period_meter: timestamp-based model plus directed waveforms.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ref_period_meter;

  localparam int W  = 28;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sig = 1'b0;
  logic [W-1:0] per_o [2];
  logic [W-1:0] hi_o  [2];
  logic         v_o   [2];
  logic         lk_o  [2];
  logic         to_o  [2];

  always #5 clk = ~clk;

  ref_period_meter #(.WIDTH(W), .AVG_LOG2(2), .TIMEOUT(28'd64)) dut_avg4 (
    .clock_in     (clk),
    .reset        (reset),
    .sig_in       (sig),
    .period_out   (per_o[0]),
    .high_out     (hi_o[0]),
    .period_valid (v_o[0]),
    .locked       (lk_o[0]),
    .timeout      (to_o[0])
  );

  ref_period_meter #(.WIDTH(W), .AVG_LOG2(0), .TIMEOUT(28'd64)) dut_avg1 (
    .clock_in     (clk),
    .reset        (reset),
    .sig_in       (sig),
    .period_out   (per_o[1]),
    .high_out     (hi_o[1]),
    .period_valid (v_o[1]),
    .locked       (lk_o[1]),
    .timeout      (to_o[1])
  );

  int  tests = 0;
  int  fails = 0;
  bit  check_en = 1'b0;
  int  vcnt [2] = '{0, 0};

  // Model: sig_in samples delayed by the synchroniser, periods from rise timestamps.
  int          alog [2] = '{2, 0};
  logic [3:0]  hist = '0;
  longint      cyc = 0;
  bit          m_run [2];
  longint      m_last [2];
  longint      m_hc [2];
  longint      m_sp [2];
  longint      m_sh [2];
  int          m_n [2];
  logic [W-1:0] e_per [2];
  logic [W-1:0] e_hi [2];
  logic         e_v [2];
  logic         e_lk [2];
  logic         e_to [2];
  bit           cs;
  bit           cr;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      hist = '0;
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_last[i] = 0; m_hc[i] = 0; m_sp[i] = 0; m_sh[i] = 0; m_n[i] = 0;
        e_per[i] = '0; e_hi[i] = '0; e_v[i] = 1'b0; e_lk[i] = 1'b0; e_to[i] = 1'b0;
      end
    end else begin
      cs   = hist[1];
      cr   = hist[1] & ~hist[2];
      hist = {hist[2:0], sig};
      for (int i = 0; i < 2; i++) begin
        e_v[i] = 1'b0;
        if (!m_run[i]) begin
          if (cr) begin
            m_run[i] = 1; m_last[i] = cyc; m_hc[i] = 0; m_n[i] = 0; m_sp[i] = 0; m_sh[i] = 0;
          end
        end else begin
          m_hc[i] += longint'(cs);
          if (cr) begin
            m_sp[i] += cyc - m_last[i];
            m_sh[i] += m_hc[i];
            m_n[i]++;
            m_last[i] = cyc;
            m_hc[i]   = 0;
            if (m_n[i] == (1 << alog[i])) begin
              e_per[i] = W'(m_sp[i] >> alog[i]);
              e_hi[i]  = W'(m_sh[i] >> alog[i]);
              e_v[i]   = 1'b1;
              e_lk[i]  = 1'b1;
              e_to[i]  = 1'b0;
              m_sp[i] = 0; m_sh[i] = 0; m_n[i] = 0;
            end
          end else if (cyc - m_last[i] + 1 >= TO) begin
            m_run[i] = 0;
            e_lk[i]  = 1'b0;
            e_to[i]  = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if ({per_o[i], hi_o[i], v_o[i], lk_o[i], to_o[i]} !==
            {e_per[i], e_hi[i], e_v[i], e_lk[i], e_to[i]}) begin
          fails++;
          $display("FAIL cycle_check dut%0d t=%0t: got per=%0d hi=%0d v=%b lk=%b to=%b, want per=%0d hi=%0d v=%b lk=%b to=%b",
                   i, $time, per_o[i], hi_o[i], v_o[i], lk_o[i], to_o[i],
                   e_per[i], e_hi[i], e_v[i], e_lk[i], e_to[i]);
        end
        if (v_o[i] === 1'b1) vcnt[i]++;
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int c);
    repeat (c) begin
      sig = 1'b1;
      tick(h);
      sig = 1'b0;
      tick(l);
    end
  endtask

  task automatic pulse_reset(input int k);
    reset = 1'b1;
    tick(k);
    reset = 1'b0;
  endtask

  int v0;
  int v1;

  initial begin
    tick(3);
    reset    = 1'b0;
    check_en = 1'b1;
    check("reset_period", longint'(per_o[0]), 0);
    check("reset_high", longint'(hi_o[0]), 0);
    check("reset_locked", longint'(lk_o[0]), 0);
    check("reset_timeout", longint'(to_o[0]), 0);
    check("reset_valid", longint'(v_o[0]), 0);
    tick(2);

    // Steady 5/5 wave: 9 rises -> windows close on rises 5 and 9
    v0 = vcnt[0]; v1 = vcnt[1];
    wave(5, 5, 9);
    check("steady_strobes_avg4", longint'(vcnt[0] - v0), 2);
    check("steady_strobes_avg1", longint'(vcnt[1] - v1), 8);
    check("steady_period", longint'(per_o[0]), 10);
    check("steady_high", longint'(hi_o[0]), 5);
    check("steady_locked", longint'(lk_o[0]), 1);

    // Alternating 9/11 periods, 4 high
    pulse_reset(2);
    repeat (2) begin
      wave(4, 5, 1);
      wave(4, 7, 1);
    end
    wave(4, 5, 1);
    check("alt_period", longint'(per_o[0]), 10);
    check("alt_high", longint'(hi_o[0]), 4);

    // Truncation: 10,10,10,11 -> 41>>2
    pulse_reset(2);
    wave(5, 5, 3);
    wave(5, 6, 1);
    wave(5, 5, 1);
    check("trunc_period", longint'(per_o[0]), 10);
    check("trunc_high", longint'(hi_o[0]), 5);
    check("trunc_period_avg1", longint'(per_o[1]), 11);

    // Timeout after lock, then recovery
    pulse_reset(2);
    wave(5, 5, 5);
    check("pre_timeout_locked", longint'(lk_o[0]), 1);
    tick(70);
    check("timeout_locked", longint'(lk_o[0]), 0);
    check("timeout_flag", longint'(to_o[0]), 1);
    check("timeout_hold_period", longint'(per_o[0]), 10);
    wave(5, 5, 5);
    check("recover_timeout", longint'(to_o[0]), 0);
    check("recover_locked", longint'(lk_o[0]), 1);

    // Reset after the second rise
    pulse_reset(2);
    wave(5, 5, 2);
    pulse_reset(1);
    check("midreset_period", longint'(per_o[0]), 0);
    check("midreset_high", longint'(hi_o[0]), 0);
    check("midreset_locked", longint'(lk_o[0]), 0);
    v0 = vcnt[0];
    wave(5, 5, 4);
    check("midreset_no_early_strobe", longint'(vcnt[0] - v0), 0);
    wave(5, 5, 1);
    check("midreset_fifth_rise_strobe", longint'(vcnt[0] - v0), 1);

    // Boundary: period 63 locks, period 64 never does
    pulse_reset(2);
    wave(32, 31, 6);
    check("p63_period", longint'(per_o[0]), 63);
    check("p63_high", longint'(hi_o[0]), 32);
    check("p63_locked", longint'(lk_o[0]), 1);
    check("p63_period_avg1", longint'(per_o[1]), 63);
    pulse_reset(2);
    v0 = vcnt[0]; v1 = vcnt[1];
    wave(32, 32, 6);
    check("p64_locked", longint'(lk_o[0]), 0);
    check("p64_timeout", longint'(to_o[0]), 1);
    check("p64_no_strobe_avg4", longint'(vcnt[0] - v0), 0);
    check("p64_no_strobe_avg1", longint'(vcnt[1] - v1), 0);

    tick(3);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
